// File: rtl/pam4_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pam4_tx : Gray-coded PAM4 transmitter with PRBS7 training preamble and
//           one-tap post-cursor ISI channel model.
// Revision : 1.0
// ============================================================================
module pam4_tx #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int SYMBOL_PERIOD     = 4,
    parameter int TRAIN_LENGTH      = 16,
    parameter int H1_SHIFT          = 1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                stop,
    input  logic [1:0]                          data_in,
    input  logic                                data_in_valid,
    output logic                                data_in_ready,
    output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic                                signal_out_valid,
    output logic signed [SIGNAL_RESOLUTION-1:0] train_data,
    output logic                                train_data_valid,
    output logic                                busy
);

    localparam int SR    = SIGNAL_RESOLUTION;
    localparam int W     = SIGNAL_RESOLUTION + 2;
    localparam int CNT_W = (SYMBOL_PERIOD > 2) ? $clog2(SYMBOL_PERIOD) : 1;
    localparam int TRN_W = $clog2(TRAIN_LENGTH + 1);

    localparam logic signed [W-1:0] LVL_N3  = W'(-((3 * SYMBOL_SEPERATION) / 2));
    localparam logic signed [W-1:0] LVL_N1  = W'(-(SYMBOL_SEPERATION / 2));
    localparam logic signed [W-1:0] LVL_P1  = W'(SYMBOL_SEPERATION / 2);
    localparam logic signed [W-1:0] LVL_P3  = W'((3 * SYMBOL_SEPERATION) / 2);
    localparam logic signed [W-1:0] SAT_MAX = W'((1 << (SR - 1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN = W'(-(1 << (SR - 1)));

    localparam logic [CNT_W-1:0] SYM_LAST   = CNT_W'(SYMBOL_PERIOD - 1);
    localparam logic [TRN_W-1:0] TRAIN_LAST = TRN_W'(TRAIN_LENGTH - 1);
    localparam logic [6:0]       LFSR_SEED  = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [TRN_W-1:0]        train_cnt_q, train_cnt_d;
    logic [6:0]              lfsr_q, lfsr_d;
    logic signed [W-1:0]     prev_level_q, prev_level_d;
    logic signed [SR-1:0]    signal_out_q, signal_out_d;
    logic                    signal_out_valid_q, signal_out_valid_d;
    logic signed [SR-1:0]    train_data_q, train_data_d;
    logic                    train_data_valid_q, train_data_valid_d;

    logic                    tick;
    logic                    emit;
    logic                    emit_train;
    logic [1:0]              sym_bits;
    logic [6:0]              lfsr_step1;
    logic [6:0]              lfsr_step2;
    logic signed [W-1:0]     level;
    logic signed [W-1:0]     isi_sum;
    logic signed [W-1:0]     sat_sum;

    assign tick          = (state_q != ST_IDLE) && (sym_cnt_q == SYM_LAST);
    assign data_in_ready = (state_q == ST_DATA) && tick;
    assign busy          = (state_q != ST_IDLE);

    // Two PRBS7 (x^7 + x^6 + 1) steps per symbol, one per Gray bit.
    assign lfsr_step1 = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    assign lfsr_step2 = {lfsr_step1[5:0], lfsr_step1[6] ^ lfsr_step1[5]};

    always_comb begin
        level = LVL_P3;
        case (sym_bits)
            2'b00:   level = LVL_N3;
            2'b01:   level = LVL_N1;
            2'b11:   level = LVL_P1;
            default: level = LVL_P3;
        endcase
    end

    // Two guard bits keep level + post-cursor from wrapping before the clamp.
    assign isi_sum = level + (prev_level_q >>> H1_SHIFT);

    always_comb begin
        sat_sum = isi_sum;
        if (isi_sum > SAT_MAX) begin
            sat_sum = SAT_MAX;
        end else if (isi_sum < SAT_MIN) begin
            sat_sum = SAT_MIN;
        end
    end

    always_comb begin
        state_d            = state_q;
        sym_cnt_d          = sym_cnt_q;
        train_cnt_d        = train_cnt_q;
        lfsr_d             = lfsr_q;
        prev_level_d       = prev_level_q;
        signal_out_d       = signal_out_q;
        signal_out_valid_d = 1'b0;
        train_data_d       = train_data_q;
        train_data_valid_d = 1'b0;
        emit               = 1'b0;
        emit_train         = 1'b0;
        sym_bits           = data_in;

        if (state_q == ST_IDLE) begin
            sym_cnt_d = '0;
        end else if (tick) begin
            sym_cnt_d = '0;
        end else begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_TRAIN;
                    sym_cnt_d    = '0;
                    train_cnt_d  = '0;
                    prev_level_d = '0;
                    lfsr_d       = LFSR_SEED;
                end
            end
            ST_TRAIN: begin
                if (tick) begin
                    emit        = 1'b1;
                    emit_train  = 1'b1;
                    sym_bits    = {lfsr_q[6], lfsr_q[5]};
                    lfsr_d      = lfsr_step2;
                    train_cnt_d = train_cnt_q + TRN_W'(1);
                    if (train_cnt_q == TRAIN_LAST) begin
                        state_d = ST_DATA;
                    end
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (data_in_ready && data_in_valid) begin
                    emit     = 1'b1;
                    sym_bits = data_in;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            signal_out_d       = sat_sum[SR-1:0];
            signal_out_valid_d = 1'b1;
            prev_level_d       = level;
        end
        if (emit_train) begin
            train_data_d       = level[SR-1:0];
            train_data_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q            <= ST_IDLE;
            sym_cnt_q          <= '0;
            train_cnt_q        <= '0;
            lfsr_q             <= LFSR_SEED;
            prev_level_q       <= '0;
            signal_out_q       <= '0;
            signal_out_valid_q <= 1'b0;
            train_data_q       <= '0;
            train_data_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            sym_cnt_q          <= sym_cnt_d;
            train_cnt_q        <= train_cnt_d;
            lfsr_q             <= lfsr_d;
            prev_level_q       <= prev_level_d;
            signal_out_q       <= signal_out_d;
            signal_out_valid_q <= signal_out_valid_d;
            train_data_q       <= train_data_d;
            train_data_valid_q <= train_data_valid_d;
        end
    end

    assign signal_out       = signal_out_q;
    assign signal_out_valid = signal_out_valid_q;
    assign train_data       = train_data_q;
    assign train_data_valid = train_data_valid_q;

endmodule
`default_nettype wire
